// File: rtl/dcache_ctrl_if.sv
// Purpose: CPU data port and 256-bit block memory bus of the data cache.
// Ports:   p1_*  - CPU MEM-stage request, store data, load data, stall
//          mem_* - block memory request, address, victim data, refill data, ack
// Modports: slave = cache side, master = CPU/memory side.
interface dcache_ctrl_if;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BLOCK_W = 256;

   logic               p1_req_i;
   logic               p1_write_i;
   logic [ADDR_W-1:0]  p1_addr_i;
   logic [WORD_W-1:0]  p1_data_i;
   logic [WORD_W-1:0]  p1_data_o;
   logic               p1_stall_o;

   logic               mem_enable_o;
   logic               mem_write_o;
   logic [ADDR_W-1:0]  mem_addr_o;
   logic [BLOCK_W-1:0] mem_data_o;
   logic [BLOCK_W-1:0] mem_data_i;
   logic               mem_ack_i;

   modport slave (
      input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport master (
      output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Purpose: direct-mapped, write-back, write-allocate data cache controller
//          (32 lines x 256 bits). Hits answer in the request cycle; misses
//          stall the CPU, write back a dirty victim, refill, then re-look up.
// Ports:   clk_i - rising-edge clock
//          rst_i - asynchronous active-low reset
//          bus   - CPU data port and block memory bus (slave modport)
module dcache_ctrl (
   input  logic          clk_i,
   input  logic          rst_i,
   dcache_ctrl_if.slave  bus
);
   localparam int unsigned LINES      = 32;
   localparam int unsigned IDX_W      = 5;
   localparam int unsigned TAG_W      = 22;
   localparam int unsigned BLOCK_BITS = 256;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ADDR_W     = 32;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_REFILL    = 2'd2,
      S_FILLDONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [LINES-1:0]      r_valid;
   logic [LINES-1:0]      r_dirty;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [BLOCK_BITS-1:0] r_data [LINES];

   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [7:0]            w_bit_off;
   logic [BLOCK_BITS-1:0] w_line;
   logic [TAG_W-1:0]      w_line_tag;
   logic [WORD_W-1:0]     w_word;
   logic [BLOCK_BITS-1:0] w_merged;
   logic                  w_hit;
   logic                  w_store_hit;
   logic                  w_fill;
   logic                  w_mem_enable;
   logic                  w_mem_write;
   logic [ADDR_W-1:0]     w_mem_addr;
   logic [BLOCK_BITS-1:0] w_mem_data;
   logic                  w_unused;

   // Address decode and line lookup
   assign w_idx      = bus.p1_addr_i[9:5];
   assign w_tag      = bus.p1_addr_i[31:10];
   assign w_bit_off  = {bus.p1_addr_i[4:2], 5'b0};
   assign w_line     = r_data[w_idx];
   assign w_line_tag = r_tag[w_idx];
   assign w_word     = w_line[w_bit_off +: WORD_W];
   assign w_unused   = ^bus.p1_addr_i[1:0];

   assign w_hit       = r_valid[w_idx] & (w_line_tag == w_tag) & (r_state == S_IDLE);
   assign w_store_hit = bus.p1_req_i & bus.p1_write_i & w_hit;
   assign w_fill      = (r_state == S_REFILL) & bus.mem_ack_i;

   // Store data merged into the current line
   always_comb begin
      w_merged = w_line;
      w_merged[w_bit_off +: WORD_W] = bus.p1_data_i;
   end

   // CPU-facing outputs are combinational; reset forces them low
   assign bus.p1_stall_o = rst_i & ((bus.p1_req_i & ~w_hit) | (r_state != S_IDLE));
   assign bus.p1_data_o  = (rst_i & bus.p1_req_i & ~bus.p1_write_i) ? w_word : WORD_W'(0);

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and memory request
   always_comb begin
      w_next       = r_state;
      w_mem_enable = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_addr   = ADDR_W'(0);
      w_mem_data   = BLOCK_BITS'(0);
      case (r_state)
         S_IDLE: begin
            if (bus.p1_req_i && !w_hit) begin
               w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
            end
         end
         S_WRITEBACK: begin
            w_mem_enable = 1'b1;
            w_mem_write  = 1'b1;
            w_mem_addr   = {w_line_tag, w_idx, 5'b0};
            w_mem_data   = w_line;
            if (bus.mem_ack_i) w_next = S_REFILL;
         end
         S_REFILL: begin
            w_mem_enable = 1'b1;
            w_mem_addr   = {bus.p1_addr_i[31:5], 5'b0};
            if (bus.mem_ack_i) w_next = S_FILLDONE;
         end
         S_FILLDONE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.mem_enable_o = w_mem_enable;
   assign bus.mem_write_o  = w_mem_write;
   assign bus.mem_addr_o   = w_mem_addr;
   assign bus.mem_data_o   = w_mem_data;

   // Valid/dirty flags: cleared by reset, set by refill and store hits
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (w_fill) begin
         r_valid[w_idx] <= 1'b1;
         r_dirty[w_idx] <= 1'b0;
      end else if (w_store_hit) begin
         r_dirty[w_idx] <= 1'b1;
      end
   end

   // Tag and data arrays keep their contents across reset
   always_ff @(posedge clk_i) begin
      if (w_fill) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= bus.mem_data_i;
      end else if (w_store_hit) begin
         r_data[w_idx] <= w_merged;
      end
   end
endmodule
